// File: rtl/sha1_pad_feeder.sv
// -----------------------------------------------------------------------------
// sha1_pad_feeder
//
// Streams a byte message held in a 32-bit little-endian DPSRAM to a SHA-1
// compression core as big-endian 32-bit message schedule words, and appends
// the SHA-1 padding on the fly: a 0x80 marker byte, zero fill, and the 64-bit
// big-endian bit length. The whole padded message goes out as one stream of
// 16-word blocks.
//
// Configuration macro: SHA1_FEED_CHK_EN
//   defined   : jobs with a misaligned start address, or with reads that would
//               run past the end of the 64 KiB DPSRAM window, are rejected
//               with a one-cycle err pulse. No read, no word, no done.
//   undefined : no check is made, err is constant 0, and message_addr[1:0]
//               is ignored (the address is treated as word aligned).
//
// Ports
//   clk              clock, all logic on the rising edge
//   nreset           synchronous active-low reset
//   start_i          begin a job (sampled only in IDLE)
//   message_addr_i   byte address of the message (captured at start)
//   message_size_i   message length in bytes (captured at start)
//   mem_addr_o       DPSRAM byte address, always word aligned
//   mem_we_o         DPSRAM write enable, always 0
//   mem_rdata_i      DPSRAM read data, valid the cycle after mem_addr_o is sampled
//   w_valid_o        w_data_o holds a padded message word
//   w_ready_i        consumer accepts the word
//   w_data_o         message schedule word W[0..15] of the current block
//   w_blast_o        with w_valid_o: word 15 of a 512-bit block
//   w_last_o         with w_valid_o: final word of the padded message
//   busy_o           a job is in progress
//   done_o           one-cycle pulse the cycle after the final handshake
//   err_o            one-cycle pulse on a rejected job
//   dbg_state_o      current FSM state (encoding of state_t)
//
// Handshake: a word transfers on a rising edge where w_valid_o and w_ready_i
// are both high. While w_valid_o is high and w_ready_i is low, w_data_o,
// w_blast_o and w_last_o hold their values; w_valid_o never drops without a
// transfer.
// -----------------------------------------------------------------------------
module sha1_pad_feeder (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start_i,
  input  logic [31:0] message_addr_i,
  input  logic [31:0] message_size_i,
  output logic [15:0] mem_addr_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_rdata_i,
  output logic        w_valid_o,
  input  logic        w_ready_i,
  output logic [31:0] w_data_o,
  output logic        w_blast_o,
  output logic        w_last_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,  // mem_addr_o presented to the DPSRAM
    ST_WAIT  = 3'd2,  // read data arrives, captured at the end of this cycle
    ST_EMIT  = 3'd3,  // offering a word that came from memory
    ST_PAD   = 3'd4,  // offering a synthesized padding/length word
    ST_DONE  = 3'd5
  } state_t;

  state_t      state_q;
  logic [15:0] base_q;      // word-aligned start address
  logic [31:0] size_q;      // message size in bytes
  logic [31:0] m_q;         // number of memory words
  logic [31:0] n_q;         // number of words in the padded stream
  logic [31:0] idx_q;       // index of the word being fetched/offered
  logic [15:0] mem_addr_q;
  logic        w_valid_q;
  logic [31:0] w_data_q;
  logic        w_blast_q;
  logic        w_last_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  // ---------------------------------------------------------------------------
  // Job geometry, computed from the live inputs for use at the start edge.
  //   M = ceil(size/4)
  //   N = 16 * (floor((size+8)/64) + 1)
  // Both sums are taken one bit wider so sizes near 2^32 do not wrap.
  // ---------------------------------------------------------------------------
  logic [32:0] size_p3_d;
  logic [32:0] size_p8_d;
  logic [26:0] blocks_d;
  logic [31:0] m_d;
  logic [31:0] n_d;
  logic [15:0] base_d;
  logic        reject_d;

  assign size_p3_d = {1'b0, message_size_i} + 33'd3;
  assign size_p8_d = {1'b0, message_size_i} + 33'd8;
  assign blocks_d  = size_p8_d[32:6] + 27'd1;
  assign m_d       = {1'b0, size_p3_d[32:2]};
  assign n_d       = {1'b0, blocks_d, 4'b0000};
  assign base_d    = {message_addr_i[15:2], 2'b00};

`ifdef SHA1_FEED_CHK_EN
  // The last read is at base+4*(M-1), so the window is overrun when
  // base+4*M goes past 64 KiB. 34 bits hold 4*M for any 32-bit size.
  logic [33:0] end_addr_d;
  assign end_addr_d = {18'd0, message_addr_i[15:0]} + {m_d, 2'b00};
  assign reject_d   = (message_addr_i[1:0] != 2'b00) || (end_addr_d > 34'h0_0001_0000);
`else
  assign reject_d   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Word formatting
  // ---------------------------------------------------------------------------
  logic [31:0] idx_nxt_d;
  logic [31:0] bswap_d;
  logic [31:0] mem_word_d;
  logic        last_mem_d;

  assign idx_nxt_d  = idx_q + 32'd1;
  assign last_mem_d = (idx_q == m_q - 32'd1);

  // The lowest-addressed byte sits in bits [7:0] of the DPSRAM word and must
  // become the most significant byte of the big-endian schedule word.
  assign bswap_d = {mem_rdata_i[7:0], mem_rdata_i[15:8],
                    mem_rdata_i[23:16], mem_rdata_i[31:24]};

  // A partial final memory word keeps its r valid bytes, then carries the
  // 0x80 marker, then zeros.
  always_comb begin
    mem_word_d = bswap_d;
    if (last_mem_d) begin
      case (size_q[1:0])
        2'd1:    mem_word_d = {bswap_d[31:24], 8'h80, 16'h0000};
        2'd2:    mem_word_d = {bswap_d[31:16], 8'h80, 8'h00};
        2'd3:    mem_word_d = {bswap_d[31:8], 8'h80};
        default: mem_word_d = bswap_d;
      endcase
    end
  end

  // Words past the memory region. When the size is a multiple of 4 the marker
  // byte needs a word of its own at index M; the length field always fills the
  // final two words. The marker word can never coincide with the length words
  // because N >= M+3 whenever the size is a multiple of 4.
  function automatic logic [31:0] synth_word(input logic [31:0] j,
                                             input logic [31:0] m,
                                             input logic [31:0] n,
                                             input logic [31:0] size);
    logic [31:0] w;
    w = 32'd0;
    if ((j == m) && (size[1:0] == 2'b00)) w = 32'h8000_0000;
    else if (j == n - 32'd2)                w = {29'd0, size[31:29]};
    else if (j == n - 32'd1)                w = {size[28:0], 3'b000};
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      base_q     <= 16'd0;
      size_q     <= 32'd0;
      m_q        <= 32'd0;
      n_q        <= 32'd0;
      idx_q      <= 32'd0;
      mem_addr_q <= 16'd0;
      w_valid_q  <= 1'b0;
      w_data_q   <= 32'd0;
      w_blast_q  <= 1'b0;
      w_last_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (reject_d) begin
              err_q <= 1'b1;
            end else begin
              base_q <= base_d;
              size_q <= message_size_i;
              m_q    <= m_d;
              n_q    <= n_d;
              idx_q  <= 32'd0;
              busy_q <= 1'b1;
              if (m_d != 32'd0) begin
                state_q    <= ST_FETCH;
                mem_addr_q <= base_d;
              end else begin
                // Empty message: the first word is already padding. N is at
                // least 16, so word 0 is never a block or stream end.
                state_q   <= ST_PAD;
                w_valid_q <= 1'b1;
                w_data_q  <= synth_word(32'd0, m_d, n_d, message_size_i);
                w_blast_q <= 1'b0;
                w_last_q  <= 1'b0;
              end
            end
          end
        end

        ST_FETCH: begin
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          state_q   <= ST_EMIT;
          w_valid_q <= 1'b1;
          w_data_q  <= mem_word_d;
          w_blast_q <= &idx_q[3:0];
          w_last_q  <= (idx_q == n_q - 32'd1);
        end

        ST_EMIT, ST_PAD: begin
          if (w_ready_i) begin
            idx_q <= idx_nxt_d;
            if (idx_nxt_d < m_q) begin
              state_q    <= ST_FETCH;
              mem_addr_q <= base_q + {idx_nxt_d[13:0], 2'b00};
              w_valid_q  <= 1'b0;
              w_data_q   <= 32'd0;
              w_blast_q  <= 1'b0;
              w_last_q   <= 1'b0;
            end else if (idx_nxt_d < n_q) begin
              state_q   <= ST_PAD;
              w_valid_q <= 1'b1;
              w_data_q  <= synth_word(idx_nxt_d, m_q, n_q, size_q);
              w_blast_q <= &idx_nxt_d[3:0];
              w_last_q  <= (idx_nxt_d == n_q - 32'd1);
            end else begin
              state_q   <= ST_DONE;
              w_valid_q <= 1'b0;
              w_data_q  <= 32'd0;
              w_blast_q <= 1'b0;
              w_last_q  <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = 1'b0;
  assign w_valid_o   = w_valid_q;
  assign w_data_o    = w_data_q;
  assign w_blast_o   = w_blast_q;
  assign w_last_o    = w_last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sha1_pad_feeder.sv
// -----------------------------------------------------------------------------
// tb_sha1_pad_feeder
//
// Directed bench for sha1_pad_feeder. A behavioural DPSRAM answers reads one
// cycle after the address is sampled. Each test task runs one scenario and
// compares the captured stream, read addresses and pulse timing against
// hand-computed values or a small byte-swap model.
// -----------------------------------------------------------------------------
module tb_sha1_pad_feeder;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EMIT  = 3'd3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        nreset;
  logic        start_i;
  logic [31:0] message_addr_i;
  logic [31:0] message_size_i;
  logic [15:0] mem_addr_o;
  logic        mem_we_o;
  logic [31:0] mem_rdata_i;
  logic        w_valid_o;
  logic        w_ready_i;
  logic [31:0] w_data_o;
  logic        w_blast_o;
  logic        w_last_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [2:0]  dbg_state_o;

  always #5 clk = ~clk;

  sha1_pad_feeder dut (
    .clk            (clk),
    .nreset         (nreset),
    .start_i        (start_i),
    .message_addr_i (message_addr_i),
    .message_size_i (message_size_i),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_rdata_i    (mem_rdata_i),
    .w_valid_o      (w_valid_o),
    .w_ready_i      (w_ready_i),
    .w_data_o       (w_data_o),
    .w_blast_o      (w_blast_o),
    .w_last_o       (w_last_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [256];
  always @(posedge clk) mem_rdata_i <= mem[mem_addr_o[9:2]];

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic        got_blast_q[$];
  logic        got_last_q[$];
  logic [15:0] rd_q[$];
  int          done_cyc, first_valid, done_cnt, err_cnt, valid_cnt;
  logic        busy_at1, unstable, timed_out;

  // ---------------- driver ----------------
  // Called just after a falling edge. The cycle after the start edge is cyc 1.
  // Inputs are scrambled after capture so late changes would show up.
  task automatic run_job(input logic [31:0] addr, input logic [31:0] size,
                         input int max_cyc, input int stall_at,
                         input int stall_len, input int glitch_cyc);
    int          cyc;
    int          stall_left;
    logic        rdy;
    logic [33:0] hold;
    got_q.delete(); got_blast_q.delete(); got_last_q.delete(); rd_q.delete();
    done_cyc = -1; first_valid = -1; done_cnt = 0; err_cnt = 0; valid_cnt = 0;
    unstable = 1'b0; timed_out = 1'b0; stall_left = stall_len; hold = '0;
    message_addr_i = addr; message_size_i = size; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; message_addr_i = 32'h0000_1234; message_size_i = 32'hdead_beef;
    busy_at1 = busy_o;
    cyc = 1;
    while (1) begin
      if (dbg_state_o == S_FETCH) rd_q.push_back(mem_addr_o);
      if (err_o) err_cnt++;
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (w_valid_o) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc;
      end
      rdy = 1'b1;
      if (stall_len > 0 && got_q.size() == stall_at) begin
        if (stall_left > 0 && (w_valid_o || stall_left != stall_len)) begin
          if (stall_left == stall_len) hold = {w_blast_o, w_last_o, w_data_o};
          else if (!w_valid_o || {w_blast_o, w_last_o, w_data_o} !== hold) unstable = 1'b1;
          rdy = 1'b0;
          stall_left--;
        end else if (stall_left == 0 && (!w_valid_o || {w_blast_o, w_last_o, w_data_o} !== hold)) begin
          unstable = 1'b1;
        end
      end
      w_ready_i = rdy;
      if (w_valid_o && rdy) begin
        got_q.push_back(w_data_o);
        got_blast_q.push_back(w_blast_o);
        got_last_q.push_back(w_last_o);
      end
      if (cyc == glitch_cyc) begin
        start_i = 1'b1; message_size_i = 32'd0; message_addr_i = 32'h0000_0040;
      end else begin
        start_i = 1'b0;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (cyc >= max_cyc) begin
        timed_out = (done_cyc < 0);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    w_ready_i = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({mem_addr_o, mem_we_o, w_valid_o, w_data_o, w_blast_o, w_last_o,
         busy_o, done_o, err_o, dbg_state_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h we=%b v=%b d=%h bl=%b l=%b busy=%b done=%b err=%b st=%0d, want all 0",
               mem_addr_o, mem_we_o, w_valid_o, w_data_o, w_blast_o, w_last_o, busy_o, done_o, err_o, dbg_state_o);
    end
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_size0();
    run_job(32'h0, 32'd0, 100, -1, 0, -1);
    exp_q.delete();
    exp_q.push_back(32'h8000_0000);
    for (int k = 1; k < 16; k++) exp_q.push_back(32'h0);
    n_tests++;
    if (timed_out !== 1'b0 || got_q.size() != 16) begin
      n_fail++; $display("FAIL size0_count: got %0d words timeout=%b, want 16 words", got_q.size(), timed_out);
    end
    n_tests++;
    if (rd_q.size() != 0) begin n_fail++; $display("FAIL size0_reads: got %0d reads, want 0", rd_q.size()); end
    n_tests++;
    if (first_valid != 1 || done_cyc != 17 || done_cnt != 1) begin
      n_fail++; $display("FAIL size0_timing: got first=%0d done=%0d cnt=%0d, want 1/17/1", first_valid, done_cyc, done_cnt);
    end
    for (int k = 0; k < 16 && k < got_q.size(); k++) begin
      n_tests++;
      if ({got_blast_q[k], got_last_q[k], got_q[k]} !== {k == 15, k == 15, exp_q[k]}) begin
        n_fail++; $display("FAIL size0_word%0d: got %b%b %h, want %b%b %h", k, got_blast_q[k], got_last_q[k], got_q[k], k == 15, k == 15, exp_q[k]);
      end
    end
  endtask

  // Also pulses start while busy and scrambles inputs after capture.
  task automatic test_size3();
    run_job(32'h0, 32'd3, 100, -1, 0, 5);
    exp_q.delete();
    exp_q.push_back(32'h6745_2380);
    for (int k = 1; k < 15; k++) exp_q.push_back(32'h0);
    exp_q.push_back(32'h0000_0018);
    n_tests++;
    if (timed_out !== 1'b0 || got_q.size() != 16) begin
      n_fail++; $display("FAIL size3_count: got %0d words timeout=%b, want 16", got_q.size(), timed_out);
    end
    n_tests++;
    if (rd_q.size() != 1 || (rd_q.size() == 1 && rd_q[0] !== 16'h0)) begin
      n_fail++; $display("FAIL size3_reads: got %0d reads, want exactly 1 at 0000", rd_q.size());
    end
    n_tests++;
    if (first_valid != 3 || done_cyc != 19 || done_cnt != 1 || busy_at1 !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL size3_timing: got first=%0d done=%0d cnt=%0d busy1=%b busy_end=%b, want 3/19/1/1/0",
                         first_valid, done_cyc, done_cnt, busy_at1, busy_o);
    end
    for (int k = 0; k < 16 && k < got_q.size(); k++) begin
      n_tests++;
      if ({got_blast_q[k], got_last_q[k], got_q[k]} !== {k == 15, k == 15, exp_q[k]}) begin
        n_fail++; $display("FAIL size3_word%0d: got %b%b %h, want %b%b %h", k, got_blast_q[k], got_last_q[k], got_q[k], k == 15, k == 15, exp_q[k]);
      end
    end
  endtask

  task automatic test_size56(input int stall_len);
    int exp_done;
    run_job(32'h0, 32'd56, 300, (stall_len > 0) ? 5 : -1, stall_len, -1);
    exp_done = 61 + stall_len;
    exp_q.delete();
    for (int k = 0; k < 14; k++) exp_q.push_back(bswap(mem[k]));
    exp_q.push_back(32'h8000_0000);
    for (int k = 15; k < 31; k++) exp_q.push_back(32'h0);
    exp_q.push_back(32'h0000_01c0);
    n_tests++;
    if (timed_out !== 1'b0 || got_q.size() != 32) begin
      n_fail++; $display("FAIL size56_count(stall=%0d): got %0d words, want 32", stall_len, got_q.size());
    end
    n_tests++;
    if (rd_q.size() != 14) begin n_fail++; $display("FAIL size56_reads(stall=%0d): got %0d, want 14", stall_len, rd_q.size()); end
    n_tests++;
    if (done_cyc != exp_done || done_cnt != 1 || unstable !== 1'b0) begin
      n_fail++; $display("FAIL size56_timing(stall=%0d): got done=%0d cnt=%0d unstable=%b, want %0d/1/0",
                         stall_len, done_cyc, done_cnt, unstable, exp_done);
    end
    for (int k = 0; k < rd_q.size(); k++) begin
      n_tests++;
      if (rd_q[k] !== 16'(4 * k)) begin n_fail++; $display("FAIL size56_addr%0d: got %h, want %h", k, rd_q[k], 16'(4 * k)); end
    end
    for (int k = 0; k < 32 && k < got_q.size(); k++) begin
      n_tests++;
      if ({got_blast_q[k], got_last_q[k], got_q[k]} !== {(k == 15) || (k == 31), k == 31, exp_q[k]}) begin
        n_fail++; $display("FAIL size56_word%0d(stall=%0d): got %b%b %h, want %b%b %h", k, stall_len, got_blast_q[k], got_last_q[k], got_q[k],
                           (k == 15) || (k == 31), k == 31, exp_q[k]);
      end
    end
  endtask

  task automatic test_size511();
    logic [31:0] t;
    run_job(32'h0, 32'd511, 1000, -1, 0, -1);
    exp_q.delete();
    for (int k = 0; k < 127; k++) exp_q.push_back(bswap(mem[k]));
    t = bswap(mem[127]);
    exp_q.push_back({t[31:8], 8'h80});
    for (int k = 128; k < 143; k++) exp_q.push_back(32'h0);
    exp_q.push_back(32'h0000_0ff8);
    n_tests++;
    if (timed_out !== 1'b0 || got_q.size() != 144) begin
      n_fail++; $display("FAIL size511_count: got %0d words, want 144", got_q.size());
    end
    n_tests++;
    if (rd_q.size() != 128) begin n_fail++; $display("FAIL size511_reads: got %0d, want 128", rd_q.size()); end
    n_tests++;
    if (done_cyc != 401 || done_cnt != 1) begin
      n_fail++; $display("FAIL size511_timing: got done=%0d cnt=%0d, want 401/1", done_cyc, done_cnt);
    end
    if (got_q.size() == 144) begin
      n_tests++;
      if ({got_q[0], got_q[1], got_q[127], got_q[143]} !== {32'h6745_2301, 32'hce8a_4602, 32'hb3a2_9180, 32'h0000_0ff8}) begin
        n_fail++; $display("FAIL size511_fixed: got %h %h %h %h, want 67452301 ce8a4602 b3a29180 00000ff8",
                           got_q[0], got_q[1], got_q[127], got_q[143]);
      end
    end
    for (int k = 0; k < rd_q.size(); k++) begin
      n_tests++;
      if (rd_q[k] !== 16'(4 * k)) begin n_fail++; $display("FAIL size511_addr%0d: got %h, want %h", k, rd_q[k], 16'(4 * k)); end
    end
    for (int k = 0; k < 144 && k < got_q.size(); k++) begin
      n_tests++;
      if ({got_blast_q[k], got_last_q[k], got_q[k]} !== {(k % 16) == 15, k == 143, exp_q[k]}) begin
        n_fail++; $display("FAIL size511_word%0d: got %b%b %h, want %b%b %h", k, got_blast_q[k], got_last_q[k], got_q[k],
                           (k % 16) == 15, k == 143, exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    message_addr_i = 32'h0; message_size_i = 32'd56; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    guard = 0;
    while (dbg_state_o != S_EMIT && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (dbg_state_o !== S_EMIT || w_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_reach_emit: got state=%0d valid=%b, want 3/1", dbg_state_o, w_valid_o);
    end
    nreset = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_addr_o, mem_we_o, w_valid_o, w_data_o, w_blast_o, w_last_o,
         busy_o, done_o, err_o, dbg_state_o} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got addr=%h v=%b d=%h busy=%b done=%b st=%0d, want all 0",
                         mem_addr_o, w_valid_o, w_data_o, busy_o, done_o, dbg_state_o);
    end
    @(negedge clk);
    n_tests++;
    if (dbg_state_o !== S_IDLE || done_o !== 1'b0 || w_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_hold: got state=%0d done=%b valid=%b, want 0/0/0", dbg_state_o, done_o, w_valid_o);
    end
    nreset = 1'b1;
    run_job(32'h0, 32'd3, 100, -1, 0, -1);
    n_tests++;
    if (got_q.size() != 16 || rd_q.size() != 1 || done_cyc != 19 || done_cnt != 1) begin
      n_fail++; $display("FAIL rstmid_restart: got words=%0d reads=%0d done=%0d cnt=%0d, want 16/1/19/1",
                         got_q.size(), rd_q.size(), done_cyc, done_cnt);
    end
    n_tests++;
    if (got_q.size() == 0 || got_q[0] !== 32'h6745_2380) begin
      n_fail++; $display("FAIL rstmid_word0: got %h, want 67452380", (got_q.size() > 0) ? got_q[0] : 32'hx);
    end
  endtask

`ifdef SHA1_FEED_CHK_EN
  task automatic test_addr_check();
    run_job(32'h0000_0002, 32'd8, 12, -1, 0, -1);
    n_tests++;
    if (err_cnt != 1 || rd_q.size() != 0 || valid_cnt != 0 || done_cnt != 0) begin
      n_fail++; $display("FAIL chk_misaligned: got err=%0d reads=%0d valid=%0d done=%0d, want 1/0/0/0",
                         err_cnt, rd_q.size(), valid_cnt, done_cnt);
    end
    run_job(32'h0000_fff0, 32'd32, 12, -1, 0, -1);
    n_tests++;
    if (err_cnt != 1 || rd_q.size() != 0 || valid_cnt != 0 || done_cnt != 0) begin
      n_fail++; $display("FAIL chk_overrun: got err=%0d reads=%0d valid=%0d done=%0d, want 1/0/0/0",
                         err_cnt, rd_q.size(), valid_cnt, done_cnt);
    end
    run_job(32'h0000_ffe0, 32'd32, 200, -1, 0, -1);
    n_tests++;
    if (err_cnt != 0 || rd_q.size() != 8 || done_cnt != 1 || got_q.size() != 32) begin
      n_fail++; $display("FAIL chk_edge_ok: got err=%0d reads=%0d done=%0d words=%0d, want 0/8/1/32",
                         err_cnt, rd_q.size(), done_cnt, got_q.size());
    end
    n_tests++;
    if (rd_q.size() == 8 && {rd_q[0], rd_q[7]} !== {16'hffe0, 16'hfffc}) begin
      n_fail++; $display("FAIL chk_edge_addr: got %h..%h, want ffe0..fffc", rd_q[0], rd_q[7]);
    end
  endtask
`else
  task automatic test_addr_check();
    run_job(32'h0000_0002, 32'd3, 100, -1, 0, -1);
    n_tests++;
    if (err_cnt != 0 || rd_q.size() != 1 || done_cnt != 1) begin
      n_fail++; $display("FAIL nochk_job: got err=%0d reads=%0d done=%0d, want 0/1/1", err_cnt, rd_q.size(), done_cnt);
    end
    n_tests++;
    if (rd_q.size() == 0 || rd_q[0] !== 16'h0 || got_q.size() == 0 || got_q[0] !== 32'h6745_2380) begin
      n_fail++; $display("FAIL nochk_aligned: got addr=%h word0=%h, want 0000 67452380",
                         (rd_q.size() > 0) ? rd_q[0] : 16'hx, (got_q.size() > 0) ? got_q[0] : 32'hx);
    end
  endtask
`endif

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    nreset = 1'b0; start_i = 1'b0; w_ready_i = 1'b1;
    message_addr_i = 32'h0; message_size_i = 32'h0;
    mem[0] = 32'h0123_4567;
    for (int k = 1; k < 256; k++) mem[k] = {mem[k-1][30:0], mem[k-1][31]};
    test_reset();
    test_size0();
    test_size3();
    test_size56(0);
    test_size56(5);
    test_size511();
    test_reset_mid();
    test_addr_check();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
